pipe_perf_monitor: RTL
======================

# pipe_perf_monitor

Parametrised, synthesizable performance monitor for the pipelined CPU. Counts run cycles and up to NUM_EVENTS pipeline event strobes, such as stall, flush and retire. Stops on its own after a programmable cycle budget. Snapshots all counters on request and streams the snapshot out over a valid/ready port. It sits beside the CPU top and takes event strobes from the hazard-detection and flush logic.

## Interface
- NUM_EVENTS, default 2: number of event inputs, range 1..16.
- CNT_WIDTH, default 32: width of every counter and of the readout word.
- MAX_CYCLES, default 64: run-cycle budget. 0 means unlimited.
- clk_i  in  1  clock. All logic is on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begins counting when sampled high in IDLE.
- clear_i  in  1  synchronous clear of counters and overflow flags. Returns the FSM to IDLE.
- event_i  in  NUM_EVENTS  one strobe per event. Bit k high adds 1 to event counter k.
- snap_req_i  in  1  capture the counters and start a readout stream.
- rd_ready_i  in  1  consumer accepts the current word.
- rd_valid_o  out  1  readout word is valid.
- rd_data_o  out  CNT_WIDTH  readout word.
- rd_idx_o  out  $clog2(NUM_EVENTS+1)  index of the word. 0 is the cycle count; k+1 is event k.
- rd_last_o  out  1  high with the final word of the stream.
- snap_busy_o  out  1  a stream is in progress.
- running_o  out  1  the FSM is in RUN.
- done_o  out  1  the FSM is in DONE.
- ovf_o  out  NUM_EVENTS+1  sticky overflow flags, in the same index order as the readout.

## Operation
- Run FSM states:
  - IDLE -> RUN when start_i=1.
  - RUN -> DONE on the edge where the cycle counter reaches MAX_CYCLES (only when MAX_CYCLES≠0).
  - Any state -> IDLE when clear_i=1.
  - DONE ignores start_i; only clear_i or reset leaves DONE.
- Counting:
  - Counting happens only in RUN. The cycle counter adds 1 every RUN cycle.
  - Event counter k adds event_i[k] every RUN cycle.
  - Events in the final RUN cycle, the one that reaches MAX_CYCLES, are counted.
- clear_i priority:
  - clear_i beats counting, start_i and the run FSM in the same cycle. Counters go to 0, ovf_o goes to 0, and the FSM goes to IDLE.
  - clear_i does not abort an active stream. The shadow copy is independent of the live counters.
- Snapshot and readout:
  - snap_req_i with snap_busy_o=0 copies every live counter into a shadow register. The copy holds register values before that edge's update, so events in the request cycle are not included.
  - snap_req_i while snap_busy_o=1 is ignored.
  - The stream is NUM_EVENTS+1 words, index 0 first.
  - A word transfers when rd_valid_o and rd_ready_i are both high. rd_idx_o then advances by 1.
  - rd_data_o and rd_idx_o stay stable while rd_valid_o=1 and rd_ready_i=0.
  - After the last word transfers, rd_valid_o and snap_busy_o drop on the next edge.
  - Snapshots are allowed in any run state, so live readout during RUN is supported.
- Readout FSM states: RD_IDLE -> RD_STREAM on an accepted snap_req_i. RD_STREAM -> RD_IDLE when the last word transfers.

## Timing
- Reset values: all counters and shadows 0, the FSM in IDLE/RD_IDLE, and every output 0.
- Reset mid-stream or mid-run aborts immediately and asynchronously to those values.
- start_i sampled at edge N: running_o is high after edge N, and the first counted cycle is cycle N+1.
- Budget: with MAX_CYCLES=M, exactly M cycles are counted. done_o rises on the edge that counts cycle M, and running_o falls on the same edge.
- snap_req_i at edge N: rd_valid_o is high after edge N with index 0. The minimum stream length is NUM_EVENTS+1 cycles when rd_ready_i is held at 1.
- A snap_req_i that arrives in the same cycle as the last-word transfer is ignored, because busy is still 1.

## Configuration
- PERF_OVERFLOW_EN defined:
  - Counters wrap from all-ones to 0.
  - The matching ovf_o bit sets on the wrap and stays high until clear_i or reset.
- PERF_OVERFLOW_EN undefined:
  - Counters saturate at all-ones.
  - ovf_o is tied to 0.

## Structure
- Package perf_pkg holds:
  - the run-state enum: IDLE, RUN, DONE;
  - the readout-state enum: RD_IDLE, RD_STREAM;
  - a localparam helper for the index width.
- One sub-module, perf_counter: a single CNT_WIDTH counter with enable, clear, and wrap/saturate handling that follows PERF_OVERFLOW_EN, plus an ovf output. It is instantiated NUM_EVENTS+1 times through generate.

## Test plan
- **Run to budget.** MAX_CYCLES=64, start_i pulsed, event_i[0] high every cycle, event_i[1] high on 10 cycles. Expect a snapshot after done_o to read 64, 64, 10. done_o rises exactly 64 edges after start.
- **Snapshot during RUN with backpressure.** Request at cycle 20 of RUN, then toggle rd_ready_i 0/1. Expect words 0, 1, 2, each held stable while stalled, rd_last_o on index 2, and live counting continuing unaffected.
- **Clear collision.** clear_i and event_i=2'b11 in the same RUN cycle. Expect all counters 0, the FSM in IDLE, and the next start_i restarting from 0.
- **Overflow.** CNT_WIDTH=4, MAX_CYCLES=0, event_i[0] high for 20 cycles.
  - With PERF_OVERFLOW_EN: count 4, ovf_o[1]=1.
  - Without it: count 15, ovf_o=0.
- **Busy snapshot ignored, and reset mid-stream.** A second snap_req_i during a stream causes no restart, and the stream still ends after 3 words. Asserting rst_i low mid-stream drops rd_valid_o at once and returns every output to 0.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared types and helpers for the pipeline performance monitor.
// Holds the run/readout state encodings and the readout index width helper.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Width of the readout index: one word for the cycle count plus one per event.
  function automatic int idx_width(input int num_events);
    return (num_events < 1) ? 1 : $clog2(num_events + 1);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one CNT_WIDTH event counter with enable and synchronous clear.
// Build option PERF_OVERFLOW_EN: defined -> wrap to 0 and raise a sticky ovf_o;
// undefined -> saturate at all-ones with ovf_o tied low.
module perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

`ifdef PERF_OVERFLOW_EN
  // Modular increment; the wrap itself is flagged separately.
  function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] c);
    return c + CNT_WIDTH'(1);
  endfunction

  // Count with wrap-around; the overflow flag is sticky until clear or reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i) begin
      cnt_o <= next_count(cnt_o);
      if (cnt_o == ALL_ONES) ovf_o <= 1'b1;
    end
  end
`else
  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] c);
    return (c == ALL_ONES) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Count with saturation; no overflow tracking in this build.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= next_count(cnt_o);
    end
  end

  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: counts RUN cycles and NUM_EVENTS pipeline event strobes,
// stops after MAX_CYCLES (0 = unlimited), and streams a snapshot of all
// counters over a valid/ready port (word 0 = cycles, word k+1 = event k).
// Build option PERF_OVERFLOW_EN selects wrap+sticky-overflow vs saturation.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int          NUM_EVENTS = 2,
  parameter int          CNT_WIDTH  = 32,
  parameter int unsigned MAX_CYCLES = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 clear_i,
  input  logic [NUM_EVENTS-1:0]                event_i,
  input  logic                                 snap_req_i,
  input  logic                                 rd_ready_i,
  output logic                                 rd_valid_o,
  output logic [CNT_WIDTH-1:0]                 rd_data_o,
  output logic [idx_width(NUM_EVENTS)-1:0]     rd_idx_o,
  output logic                                 rd_last_o,
  output logic                                 snap_busy_o,
  output logic                                 running_o,
  output logic                                 done_o,
  output logic [NUM_EVENTS:0]                  ovf_o
);

  localparam int                   NW        = NUM_EVENTS + 1;
  localparam int                   IDX_W     = idx_width(NUM_EVENTS);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_EVENTS);
  localparam bit                   BUDGET_EN = (MAX_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LAST_CYC  =
    CNT_WIDTH'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  run_state_t           run_q, run_d;
  rd_state_t            rd_q, rd_d;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_WIDTH-1:0] live   [NW];
  logic [CNT_WIDTH-1:0] shadow [NW];
  logic [NW-1:0]        cnt_en;
  logic                 in_run;
  logic                 snap_take;
  logic                 last_xfer;

  assign in_run    = (run_q == RUN);
  assign snap_take = (rd_q == RD_IDLE) && snap_req_i;
  assign last_xfer = (rd_q == RD_STREAM) && rd_ready_i && (idx_q == LAST_IDX);

  assign cnt_en[0]    = in_run;
  assign cnt_en[NW-1:1] = {NUM_EVENTS{in_run}} & event_i;

  // Slot 0 counts run cycles, slot k+1 counts event k.
  for (genvar g = 0; g < NW; g++) begin : gen_cnt
    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en[g]),
      .cnt_o (live[g]),
      .ovf_o (ovf_o[g])
    );
  end

  // Run FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) run_q <= IDLE;
    else        run_q <= run_d;
  end

  // Run FSM next state: clear wins; RUN ends on the edge that counts cycle MAX_CYCLES.
  always_comb begin
    run_d = run_q;
    if (clear_i) begin
      run_d = IDLE;
    end else begin
      case (run_q)
        IDLE:    if (start_i) run_d = RUN;
        RUN:     if (BUDGET_EN && (live[0] == LAST_CYC)) run_d = DONE;
        DONE:    run_d = DONE;
        default: run_d = IDLE;
      endcase
    end
  end

  // Run FSM outputs decoded from the registered state.
  always_comb begin
    running_o = (run_q == RUN);
    done_o    = (run_q == DONE);
  end

  // Readout FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_q <= RD_IDLE;
    else        rd_q <= rd_d;
  end

  // Readout FSM next state: requests while streaming are dropped.
  always_comb begin
    rd_d = rd_q;
    case (rd_q)
      RD_IDLE:   if (snap_req_i) rd_d = RD_STREAM;
      RD_STREAM: if (last_xfer)  rd_d = RD_IDLE;
      default:   rd_d = RD_IDLE;
    endcase
  end

  // Word index: restarts at 0 for each stream, steps on every accepted word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q <= '0;
    end else if (rd_q == RD_IDLE) begin
      idx_q <= '0;
    end else if (rd_ready_i) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow capture takes pre-edge live values, independent of later clears.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NW; i++) shadow[i] <= '0;
    end else if (snap_take) begin
      for (int i = 0; i < NW; i++) shadow[i] <= live[i];
    end
  end

  // Readout outputs; data is forced to 0 outside a stream.
  always_comb begin
    rd_valid_o  = (rd_q == RD_STREAM);
    snap_busy_o = (rd_q == RD_STREAM);
    rd_idx_o    = idx_q;
    rd_last_o   = (rd_q == RD_STREAM) && (idx_q == LAST_IDX);
    rd_data_o   = '0;
    for (int i = 0; i < NW; i++) begin
      if ((rd_q == RD_STREAM) && (idx_q == IDX_W'(i))) rd_data_o = shadow[i];
    end
  end

endmodule
